imem_loader_ctrl: RTL and testbench
===================================

Name: imem_loader_ctrl

Overview:
Controller that owns the single port of the instruction memory and shares it between two users: CPU instruction fetch and a byte-serial program loader. Normally it passes the fetch address through and returns the instruction word. On a load request it stalls the CPU, assembles incoming bytes into 32-bit words, writes them to consecutive word addresses from 0, then hands the memory back to fetch. It sits between the program counter / fetch stage and a writable instruction memory.

Parameters:
NUM_BITS_ADDR_BARRAMENTO, 32, width of the CPU byte address bus (fixed by the MIPS architecture)
NUM_BITS_MEM_PROG, 32, instruction word width (fixed by the MIPS architecture)
NUM_BITS_ADDR_PROG, 8, word-address width of program memory; depth is 2**NUM_BITS_ADDR_PROG words

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
pc_addr  in  NUM_BITS_ADDR_BARRAMENTO  CPU fetch byte address
instr  out  NUM_BITS_MEM_PROG  instruction delivered to the CPU
cpu_stall  out  1  CPU must hold its PC while this is high
load_start  in  1  single-cycle request to begin a load session
load_len  in  NUM_BITS_ADDR_PROG+1  number of words to load; sampled on the accepted load_start
byte_valid  in  1  loader byte is present
byte_data  in  8  loader byte
byte_ready  out  1  controller accepts a byte this cycle
load_busy  out  1  a load session is in progress
load_done  out  1  one-cycle pulse at the end of a session
mem_addr  out  NUM_BITS_ADDR_PROG  memory word address
mem_we  out  1  memory write enable
mem_wd  out  NUM_BITS_MEM_PROG  memory write data
mem_rd  in  NUM_BITS_MEM_PROG  memory read data (asynchronous read)

Behaviour:
- Reset: state=IDLE; byte_cnt=0, word_cnt=0, shift register=0; cpu_stall=0, load_busy=0, load_done=0, byte_ready=0, mem_we=0, mem_wd=0. A reset mid-load aborts the session immediately. Words already written stay in memory; no load_done is issued.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - mem_addr = pc_addr[NUM_BITS_ADDR_PROG+1:2]; instr = mem_rd combinationally, so fetch has zero added latency. pc_addr[1:0] is ignored.
  - cpu_stall=0.
  - On load_start=1: latch len = min(load_len, 2**NUM_BITS_ADDR_PROG), clear counters. Go to DONE if len==0, otherwise go to COLLECT.
- COLLECT:
  - byte_ready=1. A byte transfers when byte_valid && byte_ready.
  - Bytes are big-endian: the first byte goes to bits [31:24], the fourth to [7:0].
  - byte_cnt is 2 bits. When the 4th byte is accepted, go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=word_cnt, mem_wd=assembled word; byte_ready=0.
  - If word_cnt==len-1, go to DONE; otherwise increment word_cnt and go to COLLECT.
- DONE (one cycle): load_done=1, then go to IDLE.
- Outputs in COLLECT, WRITE and DONE:
  - cpu_stall=1 and load_busy=1.
  - instr=32'h00000000 (NOP), so the fetch stage sees no garbage.
  - Outside WRITE, mem_addr=word_cnt.
- cpu_stall falls in the cycle the FSM re-enters IDLE, so fetch resumes the next cycle with the memory already updated.
- load_start while busy is ignored; it is not queued.
- mem_we is never high outside WRITE.
- Maximum session length is 2**NUM_BITS_ADDR_PROG words. The last write goes to the top address, with no wrap-around.

Optional Feature:
IMEM_LOAD_CHECKSUM_EN
- Defined:
  - Adds output load_err (1 bit, reset 0).
  - The controller keeps a running XOR of all written words.
  - After the last WRITE, the FSM passes through an extra state, CHECK. CHECK collects 4 more bytes as a checksum word, which is not written to memory.
  - In DONE, load_err=1 if checksum != running XOR, otherwise 0. load_err holds until the next accepted load_start or reset.
  - With len==0 the expected checksum is 0, and the checksum word is still collected.
- Not defined: no load_err port and no CHECK state; the session ends right after the last WRITE.

Test Plan:
- Fetch passthrough: idle, memory word 5 = 32'h2008000A, pc_addr=32'h14 -> instr=32'h2008000A in the same cycle; cpu_stall=0; mem_we never asserted.
- Two-word load: load_start with load_len=2, bytes 20,08,00,01,20,09,00,02 with byte_valid held high -> mem_we pulses at word 0 (32'h20080001) and word 1 (32'h20090002); load_done one cycle later; cpu_stall released the cycle after; fetch of pc_addr=4 returns 32'h20090002.
- Throttled source: byte_valid toggling 1/0 -> same memory contents as the previous test; no byte lost or duplicated; instr=0 throughout the load.
- Boundaries: load_len=0 -> load_done the cycle after IDLE, no write. load_len=300 with NUM_BITS_ADDR_PROG=8 -> exactly 256 writes, the last to address 255.
- Reset mid-load after 6 bytes of a 2-word load -> word 0 written; IDLE next cycle; cpu_stall=0; no load_done. A load_start while busy is ignored.
- With IMEM_LOAD_CHECKSUM_EN, 2-word load plus checksum 32'h00010003 -> load_err=0; checksum 32'h00000000 -> load_err=1.

Source files
------------

// File: rtl/imem_loader_ctrl.sv
// Instruction-memory port arbiter: passes CPU fetch through, or loads a byte-serial program.
// Optional checksum verification is compiled in with IMEM_LOAD_CHECKSUM_EN.
module imem_loader_ctrl #(
  parameter int NUM_BITS_ADDR_BARRAMENTO = 32,
  parameter int NUM_BITS_MEM_PROG        = 32,
  parameter int NUM_BITS_ADDR_PROG       = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_BITS_ADDR_BARRAMENTO-1:0] pc_addr,
  output logic [NUM_BITS_MEM_PROG-1:0]        instr,
  output logic                                cpu_stall,
  input  logic                                load_start,
  input  logic [NUM_BITS_ADDR_PROG:0]         load_len,
  input  logic                                byte_valid,
  input  logic [7:0]                          byte_data,
  output logic                                byte_ready,
  output logic                                load_busy,
  output logic                                load_done,
  output logic [NUM_BITS_ADDR_PROG-1:0]       mem_addr,
  output logic                                mem_we,
  output logic [NUM_BITS_MEM_PROG-1:0]        mem_wd,
  input  logic [NUM_BITS_MEM_PROG-1:0]        mem_rd
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic                                load_err
`endif
);

`ifdef IMEM_LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE, S_CHECK} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_e;
`endif

  localparam logic [NUM_BITS_ADDR_PROG:0] MAX_LEN = {1'b1, {NUM_BITS_ADDR_PROG{1'b0}}};

  state_e                          state_q;
  logic [1:0]                      byte_cnt_q;
  logic [NUM_BITS_ADDR_PROG-1:0]   word_cnt_q;
  logic [NUM_BITS_ADDR_PROG:0]     len_q;
  logic [NUM_BITS_MEM_PROG-9:0]    shift_q;
  logic                            cpu_stall_q;
  logic                            load_busy_q;
  logic                            load_done_q;
  logic                            byte_ready_q;
  logic                            mem_we_q;
  logic [NUM_BITS_MEM_PROG-1:0]    mem_wd_q;
  logic [NUM_BITS_MEM_PROG-1:0]    word_d;
  logic                            byte_fire;
  logic                            last_word;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [NUM_BITS_MEM_PROG-1:0]    xor_q;
  logic                            load_err_q;
`endif

  // Big-endian assembly: earlier bytes end up in the higher-order bits.
  assign word_d    = {shift_q, byte_data};
  assign byte_fire = byte_valid && byte_ready_q;
  assign last_word = ({1'b0, word_cnt_q} == (len_q - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      len_q        <= '0;
      shift_q      <= '0;
      cpu_stall_q  <= 1'b0;
      load_busy_q  <= 1'b0;
      load_done_q  <= 1'b0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wd_q     <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      xor_q        <= '0;
      load_err_q   <= 1'b0;
`endif
    end else begin
      load_done_q <= 1'b0;
      mem_we_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            len_q       <= (load_len > MAX_LEN) ? MAX_LEN : load_len;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            shift_q     <= '0;
            cpu_stall_q <= 1'b1;
            load_busy_q <= 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            xor_q      <= '0;
            load_err_q <= 1'b0;
            if (load_len == '0) begin
              state_q      <= S_CHECK;
              byte_ready_q <= 1'b1;
            end else begin
              state_q      <= S_COLLECT;
              byte_ready_q <= 1'b1;
            end
`else
            if (load_len == '0) begin
              state_q     <= S_DONE;
              load_done_q <= 1'b1;
            end else begin
              state_q      <= S_COLLECT;
              byte_ready_q <= 1'b1;
            end
`endif
          end
        end
        S_COLLECT: begin
          if (byte_fire) begin
            shift_q    <= word_d[NUM_BITS_MEM_PROG-9:0];
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (byte_cnt_q == 2'd3) begin
              state_q      <= S_WRITE;
              byte_ready_q <= 1'b0;
              mem_we_q     <= 1'b1;
              mem_wd_q     <= word_d;
            end
          end
        end
        S_WRITE: begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          xor_q <= xor_q ^ mem_wd_q;
`endif
          if (last_word) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            state_q      <= S_CHECK;
            byte_ready_q <= 1'b1;
`else
            state_q     <= S_DONE;
            load_done_q <= 1'b1;
`endif
          end else begin
            word_cnt_q   <= word_cnt_q + 1'b1;
            state_q      <= S_COLLECT;
            byte_ready_q <= 1'b1;
          end
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        S_CHECK: begin
          if (byte_fire) begin
            shift_q    <= word_d[NUM_BITS_MEM_PROG-9:0];
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (byte_cnt_q == 2'd3) begin
              state_q      <= S_DONE;
              byte_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
              load_err_q   <= (word_d != xor_q);
            end
          end
        end
`endif
        S_DONE: begin
          state_q     <= S_IDLE;
          cpu_stall_q <= 1'b0;
          load_busy_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Fetch gets the memory combinationally only while idle; otherwise a NOP.
  assign mem_addr   = (state_q == S_IDLE) ? pc_addr[NUM_BITS_ADDR_PROG+1:2] : word_cnt_q;
  assign instr      = (state_q == S_IDLE) ? mem_rd : '0;
  assign cpu_stall  = cpu_stall_q;
  assign load_busy  = load_busy_q;
  assign load_done  = load_done_q;
  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_wd     = mem_wd_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign load_err   = load_err_q;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_addr[NUM_BITS_ADDR_BARRAMENTO-1:NUM_BITS_ADDR_PROG+2], pc_addr[1:0]};

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Directed bench for imem_loader_ctrl (default build): fetch passthrough, loads, boundaries, reset abort.
module tb_imem_loader_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_addr;
  logic [31:0] instr;
  logic        cpu_stall;
  logic        load_start;
  logic [8:0]  load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        load_busy;
  logic        load_done;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic        load_err;
`endif

  imem_loader_ctrl dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .instr(instr), .cpu_stall(cpu_stall),
    .load_start(load_start), .load_len(load_len), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .load_busy(load_busy),
    .load_done(load_done), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
`ifdef IMEM_LOAD_CHECKSUM_EN
    , .load_err(load_err)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];
  logic [7:0]  bytes_tb [0:1023];
  int          wr_cnt = 0;
  logic [7:0]  last_wr_addr = 8'h00;
  int          done_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rd = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] = mem_wd;
      wr_cnt        = wr_cnt + 1;
      last_wr_addr  = mem_addr;
    end
  end

  always @(negedge clk) begin
    if (load_done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    load_start = 1'b1;
    load_len   = 9'(len);
    tick();
    load_start = 1'b0;
  endtask

  // Presents bytes_tb[first +: n]; returns after the edge that accepts the last one.
  task automatic feed(input int first, input int n, input bit throttle,
                      output bit timeout, output int nop_bad);
    int idx = first;
    int cyc = 0;
    bit ph  = 1'b1;
    bit acc;
    timeout = 1'b0;
    nop_bad = 0;
    while (idx < first + n) begin
      if (cyc > n * 6 + 20) begin
        timeout = 1'b1;
        break;
      end
      byte_valid = throttle ? ph : 1'b1;
      byte_data  = bytes_tb[idx];
      #1;
      if (instr !== 32'h0 || cpu_stall !== 1'b1) nop_bad++;
      acc = byte_valid && byte_ready;
      tick();
      if (acc) idx++;
      ph = ~ph;
      cyc++;
    end
    byte_valid = 1'b0;
  endtask

  task automatic load_two_word_bytes();
    bytes_tb[0] = 8'h20; bytes_tb[1] = 8'h08; bytes_tb[2] = 8'h00; bytes_tb[3] = 8'h01;
    bytes_tb[4] = 8'h20; bytes_tb[5] = 8'h09; bytes_tb[6] = 8'h00; bytes_tb[7] = 8'h02;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({cpu_stall, load_busy, load_done, byte_ready, mem_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {cpu_stall, load_busy, load_done, byte_ready, mem_we});
    end
    n_checks++;
    if (mem_wd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem_wd: got %h expected 00000000", mem_wd);
    end
  endtask

  task automatic test_fetch();
    int w0 = wr_cnt;
    mem[5] = 32'h2008000A;
    mem[6] = 32'h11223344;
    pc_addr = 32'h14;
    #1;
    n_checks++;
    if (instr !== 32'h2008000A) begin
      n_fail++;
      $display("FAIL fetch_instr: got %h expected 2008000a", instr);
    end
    n_checks++;
    if (mem_addr !== 8'd5 || cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_addr_stall: got addr %0d stall %b expected 5 0", mem_addr, cpu_stall);
    end
    pc_addr = 32'h1B;
    #1;
    n_checks++;
    if (instr !== 32'h11223344) begin
      n_fail++;
      $display("FAIL fetch_low_bits_ignored: got %h expected 11223344", instr);
    end
    repeat (3) tick();
    n_checks++;
    if (wr_cnt !== w0) begin
      n_fail++;
      $display("FAIL fetch_no_write: got %0d writes expected 0", wr_cnt - w0);
    end
  endtask

  task automatic test_two_word();
    int w0 = wr_cnt;
    int d0 = done_cnt;
    bit to;
    int nb;
    clear_mem();
    load_two_word_bytes();
    pc_addr = 32'h0;
    start_load(2);
    feed(0, 8, 1'b0, to, nb);
    n_checks++;
    if (to || nb != 0) begin
      n_fail++;
      $display("FAIL two_word_feed: got timeout %b nop_bad %0d expected 0 0", to, nb);
    end
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'd1 || mem_wd !== 32'h20090002) begin
      n_fail++;
      $display("FAIL two_word_last_write: got we %b addr %0d wd %h expected 1 1 20090002", mem_we, mem_addr, mem_wd);
    end
    tick();
    n_checks++;
    if (load_done !== 1'b1 || cpu_stall !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL two_word_done: got done %b stall %b we %b expected 1 1 0", load_done, cpu_stall, mem_we);
    end
    tick();
    pc_addr = 32'h4;
    #1;
    n_checks++;
    if (cpu_stall !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0) begin
      n_fail++;
      $display("FAIL two_word_release: got stall %b busy %b done %b expected 0 0 0", cpu_stall, load_busy, load_done);
    end
    n_checks++;
    if (instr !== 32'h20090002) begin
      n_fail++;
      $display("FAIL two_word_fetch: got %h expected 20090002", instr);
    end
    n_checks++;
    if (mem[0] !== 32'h20080001 || wr_cnt - w0 != 2 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL two_word_mem: got w0 %h writes %0d dones %0d expected 20080001 2 1", mem[0], wr_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_throttled();
    int w0 = wr_cnt;
    int d0 = done_cnt;
    bit to;
    int nb;
    clear_mem();
    load_two_word_bytes();
    start_load(2);
    feed(0, 8, 1'b1, to, nb);
    n_checks++;
    if (to || nb != 0) begin
      n_fail++;
      $display("FAIL throttled_nop: got timeout %b nop_bad %0d expected 0 0", to, nb);
    end
    repeat (2) tick();
    n_checks++;
    if (mem[0] !== 32'h20080001 || mem[1] !== 32'h20090002) begin
      n_fail++;
      $display("FAIL throttled_mem: got %h %h expected 20080001 20090002", mem[0], mem[1]);
    end
    n_checks++;
    if (wr_cnt - w0 != 2 || done_cnt - d0 != 1 || cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL throttled_counts: got writes %0d dones %0d stall %b expected 2 1 0", wr_cnt - w0, done_cnt - d0, cpu_stall);
    end
  endtask

  task automatic test_len_zero();
    int w0 = wr_cnt;
    start_load(0);
    n_checks++;
    if (load_done !== 1'b1 || cpu_stall !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_done: got done %b stall %b we %b expected 1 1 0", load_done, cpu_stall, mem_we);
    end
    tick();
    n_checks++;
    if (load_done !== 1'b0 || cpu_stall !== 1'b0 || wr_cnt !== w0) begin
      n_fail++;
      $display("FAIL len0_end: got done %b stall %b writes %0d expected 0 0 0", load_done, cpu_stall, wr_cnt - w0);
    end
  endtask

  task automatic test_len_max();
    int w0 = wr_cnt;
    int d0 = done_cnt;
    bit to;
    int nb;
    logic [7:0] iv;
    clear_mem();
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      bytes_tb[4*i]   = 8'hA5;
      bytes_tb[4*i+1] = iv;
      bytes_tb[4*i+2] = ~iv;
      bytes_tb[4*i+3] = 8'h3C;
    end
    start_load(300);
    feed(0, 1024, 1'b0, to, nb);
    n_checks++;
    if (to || nb != 0) begin
      n_fail++;
      $display("FAIL len300_feed: got timeout %b nop_bad %0d expected 0 0", to, nb);
    end
    repeat (2) tick();
    n_checks++;
    if (wr_cnt - w0 != 256 || last_wr_addr !== 8'd255) begin
      n_fail++;
      $display("FAIL len300_writes: got %0d writes last %0d expected 256 255", wr_cnt - w0, last_wr_addr);
    end
    n_checks++;
    if (mem[0] !== 32'hA500FF3C || mem[255] !== 32'hA5FF003C || mem[128] !== 32'hA5807F3C) begin
      n_fail++;
      $display("FAIL len300_mem: got %h %h %h expected a500ff3c a5807f3c a5ff003c", mem[0], mem[128], mem[255]);
    end
    n_checks++;
    if (done_cnt - d0 != 1 || cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL len300_end: got dones %0d stall %b expected 1 0", done_cnt - d0, cpu_stall);
    end
  endtask

  task automatic test_reset_mid_load();
    int w0 = wr_cnt;
    int d0 = done_cnt;
    bit to;
    int nb;
    clear_mem();
    load_two_word_bytes();
    start_load(2);
    feed(0, 6, 1'b0, to, nb);
    start_load(0);
    n_checks++;
    if (load_busy !== 1'b1 || byte_ready !== 1'b1 || load_done !== 1'b0 || to) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got busy %b ready %b done %b timeout %b expected 1 1 0 0", load_busy, byte_ready, load_done, to);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pc_addr = 32'h0;
    #1;
    n_checks++;
    if (cpu_stall !== 1'b0 || load_busy !== 1'b0 || byte_ready !== 1'b0 || instr !== 32'h20080001) begin
      n_fail++;
      $display("FAIL reset_abort_state: got stall %b busy %b ready %b instr %h expected 0 0 0 20080001", cpu_stall, load_busy, byte_ready, instr);
    end
    repeat (3) tick();
    n_checks++;
    if (wr_cnt - w0 != 1 || done_cnt != d0 || mem[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_abort_effects: got writes %0d dones %0d w1 %h expected 1 0 00000000", wr_cnt - w0, done_cnt - d0, mem[1]);
    end
  endtask

  initial begin
    rst        = 1'b1;
    pc_addr    = 32'h0;
    load_start = 1'b0;
    load_len   = 9'd0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    clear_mem();
    test_reset();
    test_fetch();
    test_two_word();
    test_throttled();
    test_len_zero();
    test_len_max();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
